button_debounce_array: RTL and testbench
========================================

# button_debounce_array

Parametrised multi-channel debouncer for front-panel push-buttons: synchronises N raw inputs, filters bounce with a shared sample-tick prescaler and a per-channel stable-sample counter, and emits a clean level plus one-cycle press, release and long-press pulses per channel. It sits between the board I/O pins and the user-logic FSMs. It replaces per-button single debouncer instances with one block.

## Interface
- CHANNELS, 4, number of independent button channels (≥1)
- CDIV_BITS, 16, prescaler width; sample tick every 2^CDIV_BITS clocks (≥1)
- STABLE_SAMPLES, 4, consecutive differing ticks required to change the debounced level (≥1)
- LONG_TICKS, 256, ticks of continuous press before o_long pulses; 0 disables long-press (o_long tied 0)
- ACTIVE_LOW, 0, 1 = buttons pull low when pressed; inputs inverted after synchronisation

- i_clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_btn  input  CHANNELS  raw asynchronous button pins
- o_signal  output  CHANNELS  debounced level, 1 = pressed (after polarity handling)
- o_press  output  CHANNELS  one-cycle pulse on debounced 0->1
- o_release  output  CHANNELS  one-cycle pulse on debounced 1->0
- o_long  output  CHANNELS  one-cycle pulse when held LONG_TICKS ticks
- o_tick  output  1  prescaler sample strobe (debug/sharing)

## Operation
- Reset (i_rst_n low): all outputs 0 immediately; prescaler, stable and hold counters 0; 2-FF synchroniser flops load the released pin level (ACTIVE_LOW ? 1 : 0), so no spurious press after reset.
- Per channel: 2-FF synchroniser, then XOR with ACTIVE_LOW -> sample s.
- Prescaler: free-running CDIV_BITS counter, wraps; tick = (count == all ones); o_tick = tick (combinational from the register).
- Stable counter, width clog2(STABLE_SAMPLES+1), acts only on edges where tick=1:
  - s == o_signal: counter <= 0.
  - s != o_signal and counter == STABLE_SAMPLES-1: o_signal <= s, counter <= 0, o_press/o_release <= 1 per direction.
  - otherwise: counter <= counter+1.
- Any single equal sample aborts the change (counter cleared); a bouncing input never changes o_signal.
- Hold counter, width clog2(LONG_TICKS+1), saturating: cleared whenever o_signal=0; increments on each tick while o_signal=1 until LONG_TICKS; o_long <= 1 on the tick edge where it reaches LONG_TICKS. Exactly one o_long per press; re-armed only by release.
- Hold counter starts from 0 on the press edge; the first increment is the next tick.
- Channels fully independent; simultaneous transitions on several channels produce pulses on the same edge.
- Pulses are registered, high for exactly one clock, and never overlap for one channel (press and release need ≥ STABLE_SAMPLES ticks between them).

## Timing
- o_press/o_release rise on the same clock edge as the corresponding o_signal change.
- First tick edge is the 2^CDIV_BITS-th rising clock after reset deassertion; thereafter every 2^CDIV_BITS clocks.
- Press latency (clean input change to o_signal): between 2+(STABLE_SAMPLES-1)·2^CDIV_BITS+1 and 2+STABLE_SAMPLES·2^CDIV_BITS clocks.
- o_long asserts exactly LONG_TICKS·2^CDIV_BITS clocks after o_press.
- Reset assertion mid-count: all state cleared asynchronously; after release, behaviour is identical to power-up (no pulses emitted by reset itself).
- Counter wrap: prescaler wraps silently; stable counter never exceeds STABLE_SAMPLES-1; hold counter saturates.

## Test plan
Bench parameters unless noted: CHANNELS=4, CDIV_BITS=2 (tick every 4 clocks), STABLE_SAMPLES=3, LONG_TICKS=5, ACTIVE_LOW=0.
- Reset: i_rst_n low, i_btn toggling randomly -> all outputs 0 throughout; release with i_btn=0 -> no pulses for 100 clocks.
- Clean press ch0: i_btn[0] 0->1 held -> o_signal[0]=1 within 11..14 clocks, o_press[0] single 1-clock pulse on that edge; channels 1-3 remain 0; release -> o_release[0] single pulse, same latency.
- Bounce: i_btn[2] alternates 1 for 5 clocks / 0 for 5 clocks for 200 clocks -> o_signal[2], o_press[2], o_release[2] stay 0.
- Long press: hold i_btn[1]=1 for 100 clocks -> one o_long[1] pulse exactly 20 clocks after o_press[1], none after; release and re-press -> second o_long[1].
- ACTIVE_LOW=1 instance: i_btn=4'hF through reset -> o_signal=0; drive bits 1 and 3 low together -> o_signal=4'b1010 and o_press=4'b1010 on the same edge.
- Reset mid-operation: hold i_btn[0]=1, assert i_rst_n after o_press and before o_long -> outputs 0 at once; deassert with i_btn[0] still 1 -> fresh press after 11..14 clocks, o_long 20 clocks later.

Source files
------------

// File: rtl/button_debounce_array.sv
// button_debounce_array
// Multi-channel push-button debouncer. Each raw pin is synchronised through
// two flops, polarity-corrected, then filtered: the debounced level only
// changes after STABLE_SAMPLES consecutive prescaler ticks disagree with it.
// Registered one-cycle pulses are produced for press, release and long-press.
module button_debounce_array #(
  parameter int CHANNELS       = 4,
  parameter int CDIV_BITS      = 16,
  parameter int STABLE_SAMPLES = 4,
  parameter int LONG_TICKS     = 256,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_btn,
  output logic [CHANNELS-1:0] o_signal,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_long,
  output logic                o_tick
);

  localparam int SW = $clog2(STABLE_SAMPLES + 1);
  localparam int HW = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
  localparam bit LONG_EN = (LONG_TICKS > 0);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_SAMPLES - 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_TICKS);
  // Pin level of a released button; also the polarity-inversion mask.
  localparam logic [CHANNELS-1:0] REL_LVL = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  logic [CHANNELS-1:0]         sync1_q, sync2_q;
  logic [CDIV_BITS-1:0]        cnt_q, cnt_d;
  logic [CHANNELS-1:0][SW-1:0] stab_q, stab_d;
  logic [CHANNELS-1:0][HW-1:0] hold_q, hold_d;
  logic [CHANNELS-1:0]         signal_q, signal_d;
  logic [CHANNELS-1:0]         press_q, press_d;
  logic [CHANNELS-1:0]         release_q, release_d;
  logic [CHANNELS-1:0]         long_q, long_d;
  logic [CHANNELS-1:0]         samp_s;
  logic                        tick_s;

  // Two-flop synchroniser; resets to the released pin level so reset never looks like a press
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  assign samp_s = sync2_q ^ REL_LVL;
  assign tick_s = &cnt_q;

  // Next-state of prescaler, per-channel stable/hold counters and pulse outputs
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    stab_d    = stab_q;
    hold_d    = hold_q;
    signal_d  = signal_q;
    press_d   = {CHANNELS{1'b0}};
    release_d = {CHANNELS{1'b0}};
    long_d    = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      // Stable-sample filter: any agreeing sample aborts a pending change.
      if (tick_s) begin
        if (samp_s[c] == signal_q[c]) begin
          stab_d[c] = {SW{1'b0}};
        end else if (stab_q[c] == STABLE_LAST) begin
          signal_d[c]  = samp_s[c];
          stab_d[c]    = {SW{1'b0}};
          press_d[c]   = samp_s[c];
          release_d[c] = ~samp_s[c];
        end else begin
          stab_d[c] = stab_q[c] + 1'b1;
        end
      end else begin
        stab_d[c] = stab_q[c];
      end
      // Saturating hold counter; the saturation itself re-arms nothing,
      // only a release (signal low) clears it.
      if (!signal_q[c]) begin
        hold_d[c] = {HW{1'b0}};
      end else if (LONG_EN && tick_s && (hold_q[c] != LONG_MAX)) begin
        hold_d[c] = hold_q[c] + 1'b1;
        long_d[c] = (hold_d[c] == LONG_MAX);
      end else begin
        hold_d[c] = hold_q[c];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= {CDIV_BITS{1'b0}};
      stab_q    <= {(CHANNELS*SW){1'b0}};
      hold_q    <= {(CHANNELS*HW){1'b0}};
      signal_q  <= {CHANNELS{1'b0}};
      press_q   <= {CHANNELS{1'b0}};
      release_q <= {CHANNELS{1'b0}};
      long_q    <= {CHANNELS{1'b0}};
    end else begin
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
      signal_q  <= signal_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign o_signal  = signal_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_tick    = tick_s;

endmodule

// File: tb/tb_button_debounce_array.sv
// Bench for button_debounce_array: two instances (active-high and active-low
// pins), a behavioural model that predicts every output per clock edge into a
// queue, and an independent negedge monitor that pops and compares.
module tb_button_debounce_array;

  localparam int CH  = 4;
  localparam int SS  = 3;
  localparam int LT  = 5;
  localparam int PER = 4;   // clocks per sample tick (2^CDIV_BITS)

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn0, btn1;
  logic [3:0] sig0, prs0, rel0, lng0, sig1, prs1, rel1, lng1;
  logic       tck0, tck1;

  always #5 clk = ~clk;

  button_debounce_array #(.CHANNELS(CH), .CDIV_BITS(2), .STABLE_SAMPLES(SS),
                          .LONG_TICKS(LT), .ACTIVE_LOW(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn0), .o_signal(sig0), .o_press(prs0),
    .o_release(rel0), .o_long(lng0), .o_tick(tck0));

  button_debounce_array #(.CHANNELS(CH), .CDIV_BITS(2), .STABLE_SAMPLES(SS),
                          .LONG_TICKS(LT), .ACTIVE_LOW(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn1), .o_signal(sig1), .o_press(prs1),
    .o_release(rel1), .o_long(lng1), .o_tick(tck1));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  logic [16:0] exp0_q[$];
  logic [16:0] exp1_q[$];

  // Reference model state: pins seen two edges late, plus level/run/held per channel
  int         since_rst;
  logic [3:0] hist_old[2];
  logic [3:0] hist_new[2];
  int         level[2][4];
  int         run[2][4];
  int         held[2][4];

  // Monitor statistics (written only by the monitor)
  int press_cnt[4], rel_cnt[4], long_cnt[4];
  int press_at[4], rel_at[4], long_at[4];
  int pulses_total = 0;
  int sig2_hi = 0;
  int p1_edge = -1;
  logic [3:0] p1_vec = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset_all();
    since_rst = 0;
    for (int i = 0; i < 2; i++) begin
      hist_old[i] = (i == 0) ? 4'h0 : 4'hF;
      hist_new[i] = (i == 0) ? 4'h0 : 4'hF;
      for (int c = 0; c < 4; c++) begin
        level[i][c] = 0;
        run[i][c]   = 0;
        held[i][c]  = 0;
      end
    end
  endtask

  // Predict outputs after one rising edge given the pins present at that edge
  task automatic model_step(input logic [3:0] b0, input logic [3:0] b1);
    logic [3:0] s, sig, prs, rel, lng;
    logic tk;
    int old;
    if (!rst_n) model_reset_all();
    else since_rst++;
    for (int i = 0; i < 2; i++) begin
      sig = 4'h0; prs = 4'h0; rel = 4'h0; lng = 4'h0; tk = 1'b0;
      if (rst_n) begin
        s = hist_old[i] ^ ((i == 0) ? 4'h0 : 4'hF);
        hist_old[i] = hist_new[i];
        hist_new[i] = (i == 0) ? b0 : b1;
        for (int c = 0; c < 4; c++) begin
          old = level[i][c];
          if (since_rst % PER == 0) begin
            if (int'(s[c]) == level[i][c]) run[i][c] = 0;
            else if (run[i][c] + 1 == SS) begin
              level[i][c] = int'(s[c]);
              run[i][c] = 0;
              if (s[c]) prs[c] = 1'b1;
              else rel[c] = 1'b1;
            end else run[i][c]++;
            if (old == 1 && held[i][c] < LT) begin
              held[i][c]++;
              if (held[i][c] == LT) lng[c] = 1'b1;
            end
          end
          if (old == 0) held[i][c] = 0;
          sig[c] = (level[i][c] != 0);
        end
        tk = ((since_rst + 1) % PER == 0);
      end
      if (i == 0) exp0_q.push_back({sig, prs, rel, lng, tk});
      else exp1_q.push_back({sig, prs, rel, lng, tk});
    end
  endtask

  // One clock: apply pins, let the edge happen, predict, then step off the edge
  task automatic cyc(input logic [3:0] b0, input logic [3:0] b1);
    btn0 = b0;
    btn1 = b1;
    @(posedge clk);
    cyc_n++;
    model_step(b0, b1);
    #1;
  endtask

  // Monitor: pop the prediction for the latest edge and compare on the falling edge
  initial begin
    logic [16:0] e;
    for (int c = 0; c < 4; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      press_at[c] = -1000; rel_at[c] = -1000; long_at[c] = -1000;
    end
    forever begin
      @(negedge clk);
      if (exp0_q.size() > 0) begin
        e = exp0_q.pop_front();
        check("dut0_outputs", {15'h0, sig0, prs0, rel0, lng0, tck0}, {15'h0, e});
      end
      if (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        check("dut1_outputs", {15'h0, sig1, prs1, rel1, lng1, tck1}, {15'h0, e});
      end
      for (int c = 0; c < 4; c++) begin
        if (prs0[c]) begin press_cnt[c]++; press_at[c] = cyc_n; end
        if (rel0[c]) begin rel_cnt[c]++;   rel_at[c]   = cyc_n; end
        if (lng0[c]) begin long_cnt[c]++;  long_at[c]  = cyc_n; end
      end
      if ((prs0 | rel0 | lng0 | prs1 | rel1 | lng1) != 4'h0) pulses_total++;
      if (sig0[2]) sig2_hi++;
      if (prs1 != 4'h0 && p1_edge < 0) begin
        p1_edge = cyc_n;
        p1_vec  = prs1;
      end
    end
  end

  // Stimulus
  initial begin
    int p, r, l, t0, lat, pt, h;
    logic [3:0] v0, v1;
    rst_n = 1'b0;
    btn0  = 4'h0;
    btn1  = 4'hF;
    model_reset_all();

    // Reset held with dut0 pins toggling randomly
    repeat (20) cyc(4'($urandom), 4'hF);
    cyc(4'h0, 4'hF);
    rst_n = 1'b1;
    pt = pulses_total;
    repeat (100) cyc(4'h0, 4'hF);
    check("no_pulses_after_reset", pulses_total - pt, 0);

    // Clean press and release on channel 0
    p = press_cnt[0]; t0 = cyc_n;
    repeat (30) cyc(4'b0001, 4'hF);
    check("press0_count", press_cnt[0] - p, 1);
    lat = press_at[0] - t0;
    check("press0_latency_11_14", (lat >= 11 && lat <= 14), 1);
    r = rel_cnt[0]; t0 = cyc_n;
    repeat (30) cyc(4'b0000, 4'hF);
    check("release0_count", rel_cnt[0] - r, 1);
    lat = rel_at[0] - t0;
    check("release0_latency_11_14", (lat >= 11 && lat <= 14), 1);

    // Bouncing channel 2: 5 clocks high / 5 clocks low
    p = press_cnt[2]; r = rel_cnt[2]; h = sig2_hi;
    for (int k = 0; k < 200; k++) cyc(((k / 5) % 2 == 0) ? 4'b0100 : 4'b0000, 4'hF);
    repeat (20) cyc(4'b0000, 4'hF);
    check("bounce2_press", press_cnt[2] - p, 0);
    check("bounce2_release", rel_cnt[2] - r, 0);
    check("bounce2_signal_high", sig2_hi - h, 0);

    // Long press on channel 1, then release and re-press
    p = press_cnt[1]; l = long_cnt[1];
    repeat (100) cyc(4'b0010, 4'hF);
    check("long1_press_count", press_cnt[1] - p, 1);
    check("long1_count", long_cnt[1] - l, 1);
    check("long1_delay_20", long_at[1] - press_at[1], 20);
    repeat (30) cyc(4'b0000, 4'hF);
    repeat (40) cyc(4'b0010, 4'hF);
    check("long1_second", long_cnt[1] - l, 2);
    check("long1_delay2_20", long_at[1] - press_at[1], 20);
    repeat (30) cyc(4'b0000, 4'hF);

    // Active-low instance: bits 1 and 3 pulled low together
    repeat (30) cyc(4'h0, 4'b0101);
    check("al_press_vector", p1_vec, 4'b1010);
    check("al_signal", sig1, 4'b1010);
    repeat (30) cyc(4'h0, 4'hF);
    check("al_signal_released", sig1, 4'b0000);

    // Reset in the middle of a held press
    p = press_cnt[0]; l = long_cnt[0];
    for (int k = 0; k < 20 && press_cnt[0] == p; k++) cyc(4'b0001, 4'hF);
    check("midrst_first_press", press_cnt[0] - p, 1);
    repeat (8) cyc(4'b0001, 4'hF);
    rst_n = 1'b0;
    model_reset_all();
    void'(exp0_q.pop_back()); exp0_q.push_back(17'h0);
    void'(exp1_q.pop_back()); exp1_q.push_back(17'h0);
    #1;
    check("midrst_outputs_zero", {15'h0, sig0, prs0, rel0, lng0, tck0}, 32'h0);
    repeat (3) cyc(4'b0001, 4'hF);
    rst_n = 1'b1;
    t0 = cyc_n; p = press_cnt[0];
    for (int k = 0; k < 30 && press_cnt[0] == p; k++) cyc(4'b0001, 4'hF);
    check("midrst_fresh_press", press_cnt[0] - p, 1);
    lat = press_at[0] - t0;
    check("midrst_latency_11_14", (lat >= 11 && lat <= 14), 1);
    repeat (25) cyc(4'b0001, 4'hF);
    check("midrst_long_count", long_cnt[0] - l, 1);
    check("midrst_long_delay_20", long_at[0] - press_at[0], 20);

    // Randomised slowly-changing pins on both instances
    v0 = 4'h0; v1 = 4'hF;
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) v0[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) v1[$urandom_range(0, 3)] ^= 1'b1;
      cyc(v0, v1);
    end
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
